// File: rtl/store_write_port.sv
// ---------------------------------------------------------------------------
// store_write_port
//   Write port between the MEM stage and a byte-enabled RAM. Stores are
//   lane-aligned when they are accepted, held in a 2-entry FIFO, and issued
//   to the RAM one at a time by a two-state (IDLE/WRITE) FSM. Each write is
//   held until the RAM acknowledges it.
//
//   Optional feature, macro MISALIGN_EXC_EN:
//     defined   - illegal stores (unknown size code, or a half/word store
//                 that is not naturally aligned) are consumed but not
//                 enqueued. addr_error pulses for one cycle and bad_addr
//                 captures the offending address.
//     undefined - the address is forced to natural alignment, an unknown
//                 size code is treated as a word, and addr_error and
//                 bad_addr are tied to zero.
//
// Ports
//   clk, rst        clock, asynchronous active-high reset
//   st_valid        store request from the MEM stage
//   st_ready        a store can be accepted this cycle (count != 2)
//   st_addr/data    byte address / right-justified store data
//   st_sel          size code: 0001 byte, 0011 half, 1111 word
//   ram_en          RAM write request (high only in WRITE)
//   ram_write_en    per-byte write enables
//   ram_addr        word address {addr[31:2],2'b00}
//   ram_write_data  lane-aligned write data
//   ram_ack         RAM has accepted the current write (ignored in IDLE)
//   buf_empty       nothing pending and FSM idle
//   addr_error      one-cycle pulse after a rejected store
//   bad_addr        address of the last rejected store
// ---------------------------------------------------------------------------
module store_write_port (
  input  logic        clk,
  input  logic        rst,
  input  logic        st_valid,
  output logic        st_ready,
  input  logic [31:0] st_addr,
  input  logic [31:0] st_data,
  input  logic [3:0]  st_sel,
  output logic        ram_en,
  output logic [3:0]  ram_write_en,
  output logic [31:0] ram_addr,
  output logic [31:0] ram_write_data,
  input  logic        ram_ack,
  output logic        buf_empty,
  output logic        addr_error,
  output logic [31:0] bad_addr
);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    WRITE = 1'b1
  } state_t;

  state_t      state_r;

  // FIFO storage: an entry is already aligned (word address, lanes, data)
  logic [31:0] mem_addr_r [2];
  logic [3:0]  mem_we_r   [2];
  logic [31:0] mem_data_r [2];
  logic        wr_ptr_r;
  logic        rd_ptr_r;
  logic [1:0]  count_r;

  logic        st_ready_r;
  logic        ram_en_r;
  logic [3:0]  ram_write_en_r;
  logic [31:0] ram_addr_r;
  logic [31:0] ram_write_data_r;
  logic        buf_empty_r;

  logic [3:0]  al_we_s;
  logic [31:0] al_data_s;
  logic [31:0] al_addr_s;
  logic        accept_s;
  logic        push_s;
  logic        pop_s;
  logic [1:0]  count_next_s;
  logic [31:0] follow_addr_s;
  logic [3:0]  follow_we_s;
  logic [31:0] follow_data_s;

  // Replicate the low byte/half across all lanes; the enables pick the lane
  function automatic logic [31:0] lane_data(input logic [3:0] sel, input logic [31:0] d);
    case (sel)
      4'b0001: lane_data = {4{d[7:0]}};
      4'b0011: lane_data = {2{d[15:0]}};
      default: lane_data = d;
    endcase
  endfunction

  // Byte enables; a half only looks at addr[1], so bit 0 is forced clear
  function automatic logic [3:0] lane_we(input logic [3:0] sel, input logic [1:0] a);
    case (sel)
      4'b0001: lane_we = 4'b0001 << a;
      4'b0011: lane_we = a[1] ? 4'b1100 : 4'b0011;
      default: lane_we = 4'b1111;
    endcase
  endfunction

  // Align the incoming store at acceptance time
  always_comb begin
    al_we_s   = lane_we(st_sel, st_addr[1:0]);
    al_data_s = lane_data(st_sel, st_data);
    al_addr_s = {st_addr[31:2], 2'b00};
  end

`ifdef MISALIGN_EXC_EN
  logic        legal_s;
  logic        addr_error_r;
  logic [31:0] bad_addr_r;

  // Legal codes only, each at its natural alignment
  always_comb begin
    case (st_sel)
      4'b0001: legal_s = 1'b1;
      4'b0011: legal_s = (st_addr[0] == 1'b0);
      4'b1111: legal_s = (st_addr[1:0] == 2'b00);
      default: legal_s = 1'b0;
    endcase
  end

  assign push_s = accept_s && legal_s;

  // Rejected stores: pulse the error and remember the address
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_error_r <= 1'b0;
      bad_addr_r   <= 32'd0;
    end else if (accept_s && !legal_s) begin
      addr_error_r <= 1'b1;
      bad_addr_r   <= st_addr;
    end else begin
      addr_error_r <= 1'b0;
    end
  end

  assign addr_error = addr_error_r;
  assign bad_addr   = bad_addr_r;
`else
  assign push_s     = accept_s;
  assign addr_error = 1'b0;
  assign bad_addr   = 32'd0;
`endif

  assign accept_s = st_valid && st_ready_r;
  assign pop_s    = (state_r == WRITE) && ram_ack;

  // Occupancy after this edge; push+pop together leaves it unchanged
  always_comb begin
    case ({push_s, pop_s})
      2'b10:   count_next_s = count_r + 2'd1;
      2'b01:   count_next_s = count_r - 2'd1;
      default: count_next_s = count_r;
    endcase
  end

  // Entry presented after popping the head: the other slot when full,
  // otherwise the store being pushed on this same edge
  always_comb begin
    if (count_r == 2'd2) begin
      follow_addr_s = mem_addr_r[~rd_ptr_r];
      follow_we_s   = mem_we_r[~rd_ptr_r];
      follow_data_s = mem_data_r[~rd_ptr_r];
    end else begin
      follow_addr_s = al_addr_s;
      follow_we_s   = al_we_s;
      follow_data_s = al_data_s;
    end
  end

  // FIFO storage, pointers, occupancy and the registered ready flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_addr_r[0] <= 32'd0;
      mem_addr_r[1] <= 32'd0;
      mem_we_r[0]   <= 4'd0;
      mem_we_r[1]   <= 4'd0;
      mem_data_r[0] <= 32'd0;
      mem_data_r[1] <= 32'd0;
      wr_ptr_r      <= 1'b0;
      rd_ptr_r      <= 1'b0;
      count_r       <= 2'd0;
      st_ready_r    <= 1'b1;
    end else begin
      if (push_s) begin
        mem_addr_r[wr_ptr_r] <= al_addr_s;
        mem_we_r[wr_ptr_r]   <= al_we_s;
        mem_data_r[wr_ptr_r] <= al_data_s;
        wr_ptr_r             <= ~wr_ptr_r;
      end
      if (pop_s) begin
        rd_ptr_r <= ~rd_ptr_r;
      end
      count_r    <= count_next_s;
      st_ready_r <= (count_next_s != 2'd2);
    end
  end

  // Write FSM with registered RAM-side outputs and buf_empty
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r          <= IDLE;
      ram_en_r         <= 1'b0;
      ram_write_en_r   <= 4'd0;
      ram_addr_r       <= 32'd0;
      ram_write_data_r <= 32'd0;
      buf_empty_r      <= 1'b1;
    end else begin
      case (state_r)
        IDLE: begin
          if (count_r != 2'd0) begin
            state_r          <= WRITE;
            ram_en_r         <= 1'b1;
            ram_addr_r       <= mem_addr_r[rd_ptr_r];
            ram_write_en_r   <= mem_we_r[rd_ptr_r];
            ram_write_data_r <= mem_data_r[rd_ptr_r];
            buf_empty_r      <= 1'b0;
          end else begin
            buf_empty_r <= !push_s;
          end
        end
        WRITE: begin
          if (ram_ack) begin
            if (count_next_s != 2'd0) begin
              ram_addr_r       <= follow_addr_s;
              ram_write_en_r   <= follow_we_s;
              ram_write_data_r <= follow_data_s;
              buf_empty_r      <= 1'b0;
            end else begin
              state_r        <= IDLE;
              ram_en_r       <= 1'b0;
              ram_write_en_r <= 4'd0;
              buf_empty_r    <= 1'b1;
            end
          end
        end
        default: begin
          state_r  <= IDLE;
          ram_en_r <= 1'b0;
        end
      endcase
    end
  end

  assign st_ready       = st_ready_r;
  assign ram_en         = ram_en_r;
  assign ram_write_en   = ram_write_en_r;
  assign ram_addr       = ram_addr_r;
  assign ram_write_data = ram_write_data_r;
  assign buf_empty      = buf_empty_r;

endmodule

// File: tb/tb_store_write_port.sv
// ---------------------------------------------------------------------------
// tb_store_write_port
//   Directed bench for store_write_port: a table of single-store vectors with
//   hand-computed RAM-side results, plus hand-written sequences for latency,
//   held writes, push+pop on one edge, back-to-back fill and reset mid-write.
//   Inputs change and outputs are sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_store_write_port;

  logic        clk = 1'b0;
  logic        rst;
  logic        st_valid;
  logic        st_ready;
  logic [31:0] st_addr;
  logic [31:0] st_data;
  logic [3:0]  st_sel;
  logic        ram_en;
  logic [3:0]  ram_write_en;
  logic [31:0] ram_addr;
  logic [31:0] ram_write_data;
  logic        ram_ack;
  logic        buf_empty;
  logic        addr_error;
  logic [31:0] bad_addr;

  int checks = 0;
  int errors = 0;

  store_write_port dut (
    .clk(clk), .rst(rst),
    .st_valid(st_valid), .st_ready(st_ready), .st_addr(st_addr),
    .st_data(st_data), .st_sel(st_sel),
    .ram_en(ram_en), .ram_write_en(ram_write_en), .ram_addr(ram_addr),
    .ram_write_data(ram_write_data), .ram_ack(ram_ack),
    .buf_empty(buf_empty), .addr_error(addr_error), .bad_addr(bad_addr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  sel;
    logic [31:0] exp_addr;
    logic [3:0]  exp_we;
    logic [31:0] exp_data;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic drive(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    st_valid = 1'b1;
    st_addr  = a;
    st_data  = d;
    st_sel   = s;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    st_valid = 1'b0;
    ram_ack  = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    tick();
  endtask

  initial begin
    st_valid = 1'b0; st_addr = 32'd0; st_data = 32'd0; st_sel = 4'd0;
    ram_ack  = 1'b0;
    rst      = 1'b1;

    vecs.push_back('{32'h0000_1003, 32'h0000_00AB, 4'b0001, 32'h0000_1000, 4'b1000, 32'hABAB_ABAB});
    vecs.push_back('{32'h0000_2002, 32'h0000_1234, 4'b0011, 32'h0000_2000, 4'b1100, 32'h1234_1234});
    vecs.push_back('{32'h0000_4000, 32'hDEAD_BEEF, 4'b1111, 32'h0000_4000, 4'b1111, 32'hDEAD_BEEF});
    vecs.push_back('{32'h0000_5001, 32'hFFFF_FF55, 4'b0001, 32'h0000_5000, 4'b0010, 32'h5555_5555});
    vecs.push_back('{32'h0000_6000, 32'hFFFF_CAFE, 4'b0011, 32'h0000_6000, 4'b0011, 32'hCAFE_CAFE});
    vecs.push_back('{32'h0000_6402, 32'h0000_0077, 4'b0001, 32'h0000_6400, 4'b0100, 32'h7777_7777});
`ifndef MISALIGN_EXC_EN
    // forced alignment and unknown size code treated as word
    vecs.push_back('{32'h0000_3001, 32'h0BAD_F00D, 4'b1111, 32'h0000_3000, 4'b1111, 32'h0BAD_F00D});
    vecs.push_back('{32'h0000_7003, 32'h0000_BEEF, 4'b0011, 32'h0000_7000, 4'b1100, 32'hBEEF_BEEF});
    vecs.push_back('{32'h0000_8002, 32'h1357_9BDF, 4'b0101, 32'h0000_8000, 4'b1111, 32'h1357_9BDF});
`endif

    // reset values while rst is held
    tick();
    check("rst_st_ready",  {31'd0, st_ready},  32'd1);
    check("rst_buf_empty", {31'd0, buf_empty}, 32'd1);
    check("rst_ram_en",    {31'd0, ram_en},    32'd0);
    check("rst_we",        {28'd0, ram_write_en}, 32'd0);
    check("rst_addr",      ram_addr,        32'd0);
    check("rst_data",      ram_write_data,  32'd0);
    check("rst_addr_error",{31'd0, addr_error}, 32'd0);
    check("rst_bad_addr",  bad_addr,        32'd0);
    do_reset();

    // table: one store into an empty buffer, ack on the first write cycle
    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].addr, vecs[i].data, vecs[i].sel);
      tick();                       // accepted at this edge (N)
      st_valid = 1'b0;
      check($sformatf("v%0d_lat_n", i), {31'd0, ram_en}, 32'd0);
      check($sformatf("v%0d_not_empty", i), {31'd0, buf_empty}, 32'd0);
      tick();                       // edge N+1
      check($sformatf("v%0d_en", i),   {31'd0, ram_en}, 32'd1);
      check($sformatf("v%0d_addr", i), ram_addr, vecs[i].exp_addr);
      check($sformatf("v%0d_we", i),   {28'd0, ram_write_en}, {28'd0, vecs[i].exp_we});
      check($sformatf("v%0d_data", i), ram_write_data, vecs[i].exp_data);
      ram_ack = 1'b1;
      tick();
      ram_ack = 1'b0;
      check($sformatf("v%0d_done_en", i),    {31'd0, ram_en}, 32'd0);
      check($sformatf("v%0d_done_empty", i), {31'd0, buf_empty}, 32'd1);
    end

    // half store held through a 3-cycle ack delay, then push+pop on one edge
    drive(32'h0000_2002, 32'h0000_1234, 4'b0011);
    tick();
    st_valid = 1'b0;
    tick();
    for (int k = 0; k < 3; k++) begin
      check($sformatf("hold%0d_en", k),   {31'd0, ram_en}, 32'd1);
      check($sformatf("hold%0d_we", k),   {28'd0, ram_write_en}, 32'h0000_000C);
      check($sformatf("hold%0d_data", k), ram_write_data, 32'h1234_1234);
      check($sformatf("hold%0d_addr", k), ram_addr, 32'h0000_2000);
      tick();
    end
    ram_ack = 1'b1;
    drive(32'h0000_0902, 32'h0000_0011, 4'b0001);
    tick();
    st_valid = 1'b0;
    ram_ack  = 1'b0;
    check("pp_en",    {31'd0, ram_en}, 32'd1);
    check("pp_addr",  ram_addr, 32'h0000_0900);
    check("pp_we",    {28'd0, ram_write_en}, 32'h0000_0004);
    check("pp_data",  ram_write_data, 32'h1111_1111);
    check("pp_ready", {31'd0, st_ready}, 32'd1);
    ram_ack = 1'b1;
    tick();
    ram_ack = 1'b0;
    check("pp_done_en", {31'd0, ram_en}, 32'd0);

    // back-to-back: A, B fill the FIFO, C waits for space
    drive(32'h0000_0100, 32'hAAAA_0001, 4'b1111);
    tick();
    drive(32'h0000_0204, 32'hBBBB_0002, 4'b1111);
    tick();
    drive(32'h0000_0308, 32'hCCCC_0003, 4'b1111);
    check("b2b_full_ready", {31'd0, st_ready}, 32'd0);
    check("b2b_a_addr", ram_addr, 32'h0000_0100);
    tick();
    tick();
    check("b2b_c_blocked", {31'd0, st_ready}, 32'd0);
    check("b2b_a_held", ram_addr, 32'h0000_0100);
    ram_ack = 1'b1;
    tick();                         // A written, B presented, C still blocked
    ram_ack = 1'b0;
    check("b2b_b_en",    {31'd0, ram_en}, 32'd1);
    check("b2b_b_addr",  ram_addr, 32'h0000_0204);
    check("b2b_b_data",  ram_write_data, 32'hBBBB_0002);
    check("b2b_ready1",  {31'd0, st_ready}, 32'd1);
    tick();                         // C accepted
    st_valid = 1'b0;
    check("b2b_b_hold",  ram_addr, 32'h0000_0204);
    check("b2b_full2",   {31'd0, st_ready}, 32'd0);
    ram_ack = 1'b1;
    tick();
    check("b2b_c_en",    {31'd0, ram_en}, 32'd1);
    check("b2b_c_addr",  ram_addr, 32'h0000_0308);
    check("b2b_c_data",  ram_write_data, 32'hCCCC_0003);
    tick();
    ram_ack = 1'b0;
    check("b2b_done_en",    {31'd0, ram_en}, 32'd0);
    check("b2b_done_empty", {31'd0, buf_empty}, 32'd1);

`ifdef MISALIGN_EXC_EN
    // misaligned word is consumed, flagged, and never written
    drive(32'h0000_3001, 32'h0BAD_F00D, 4'b1111);
    tick();
    st_valid = 1'b0;
    check("mis_err",      {31'd0, addr_error}, 32'd1);
    check("mis_bad_addr", bad_addr, 32'h0000_3001);
    check("mis_empty",    {31'd0, buf_empty}, 32'd1);
    tick();
    check("mis_err_pulse", {31'd0, addr_error}, 32'd0);
    check("mis_no_write",  {31'd0, ram_en}, 32'd0);
    check("mis_bad_keep",  bad_addr, 32'h0000_3001);
`endif

    // reset asserted mid-write with two entries pending
    drive(32'h0000_0A00, 32'h1111_2222, 4'b1111);
    tick();
    drive(32'h0000_0B00, 32'h3333_4444, 4'b1111);
    tick();
    st_valid = 1'b0;
    check("mid_pre_en",    {31'd0, ram_en}, 32'd1);
    check("mid_pre_ready", {31'd0, st_ready}, 32'd0);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_en",    {31'd0, ram_en}, 32'd0);
    check("mid_rst_empty", {31'd0, buf_empty}, 32'd1);
    check("mid_rst_ready", {31'd0, st_ready}, 32'd1);
    tick();
    rst = 1'b0;
    ram_ack = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      check($sformatf("post_rst%0d_en", k), {31'd0, ram_en}, 32'd0);
    end
    ram_ack = 1'b0;
    check("post_rst_empty", {31'd0, buf_empty}, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
